// File: rtl/usbf_mem_sched_if.sv
// Bus bundle between the SSRAM access scheduler, its three requesters and the
// single-port packet SSRAM.
//   sram_*  : SSRAM address/data/strobes (sram_din valid the cycle after address)
//   rN_*    : per-requester req/ack access channel, N = 0 (IDMA), 1 (WISHBONE), 2 (aux)
//   owner   : requester currently in its ACK phase, 3 = none
// Modport master is the scheduler; slave is the requester/SSRAM side.
interface usbf_mem_sched_if #(
    parameter int unsigned SSRAM_HADR = 14
);
    localparam int unsigned AW = SSRAM_HADR + 1;

    logic [AW-1:0] sram_adr;
    logic [31:0]   sram_dout;
    logic [31:0]   sram_din;
    logic          sram_we;
    logic          sram_re;

    logic          r0_req, r1_req, r2_req;
    logic          r0_we,  r1_we,  r2_we;
    logic [AW-1:0] r0_adr, r1_adr, r2_adr;
    logic [31:0]   r0_din, r1_din, r2_din;
    logic [31:0]   r0_dout, r1_dout, r2_dout;
    logic          r0_ack, r1_ack, r2_ack;

    logic [1:0]    owner;

    modport master (
        output sram_adr, sram_dout, sram_we, sram_re,
        input  sram_din,
        input  r0_req, r1_req, r2_req, r0_we, r1_we, r2_we,
        input  r0_adr, r1_adr, r2_adr, r0_din, r1_din, r2_din,
        output r0_dout, r1_dout, r2_dout, r0_ack, r1_ack, r2_ack,
        output owner
    );

    modport slave (
        input  sram_adr, sram_dout, sram_we, sram_re,
        output sram_din,
        output r0_req, r1_req, r2_req, r0_we, r1_we, r2_we,
        output r0_adr, r1_adr, r2_adr, r0_din, r1_din, r2_din,
        input  r0_dout, r1_dout, r2_dout, r0_ack, r1_ack, r2_ack,
        input  owner
    );
endinterface

// File: rtl/usbf_mem_sched.sv
// Three-requester SSRAM access scheduler. Each access takes an ISSUE cycle
// (winner drives the SSRAM) followed by an ACK cycle (winner gets rN_ack and
// read data). Arbitration: starved r1/r2 first, then burst continuation of the
// previous owner, then r0, then r1/r2 round-robin.
//   phy_clk : clock
//   rst     : synchronous active-high reset
//   bus     : scheduler side of usbf_mem_sched_if (SSRAM + requester channels)
module usbf_mem_sched #(
    parameter int unsigned SSRAM_HADR = 14,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic             phy_clk,
    input  logic             rst,
    usbf_mem_sched_if.master bus
);
    localparam int unsigned AW   = SSRAM_HADR + 1;
    localparam int unsigned CW   = 4;
    localparam logic [1:0]  NONE = 2'd3;

    typedef enum logic {ST_ISSUE, ST_ACK} state_t;

    state_t          state_q, state_d;
    logic [1:0]      last_q, last_d;        // owner of the most recent grant
    logic [CW-1:0]   burst_q, burst_d;
    logic [1:0]      rr_last_q, rr_last_d;
    logic [CW-1:0]   wait1_q, wait1_d;
    logic [CW-1:0]   wait2_q, wait2_d;

    // Requester channels as index-able vectors; slot 3 is a permanently idle dummy
    logic [3:0]      req_v;
    logic [3:0]      we_v;
    logic [AW-1:0]   adr_v [4];
    logic [31:0]     din_v [4];

    assign req_v    = {1'b0, bus.r2_req, bus.r1_req, bus.r0_req};
    assign we_v     = {1'b0, bus.r2_we,  bus.r1_we,  bus.r0_we};
    assign adr_v[0] = bus.r0_adr;
    assign adr_v[1] = bus.r1_adr;
    assign adr_v[2] = bus.r2_adr;
    assign adr_v[3] = '0;
    assign din_v[0] = bus.r0_din;
    assign din_v[1] = bus.r1_din;
    assign din_v[2] = bus.r2_din;
    assign din_v[3] = '0;

    // Winner selection
    logic       starve1, starve2, cont, win_vld;
    logic [1:0] rr_pick, win;

    always_comb begin
        starve1 = req_v[1] && (wait1_q == CW'(STARVE_LIM));
        starve2 = req_v[2] && (wait2_q == CW'(STARVE_LIM));
        cont    = (last_q != NONE) && req_v[last_q] && (burst_q < CW'(MAX_BURST));
        win_vld = |req_v;
        if (req_v[1] && req_v[2]) begin
            rr_pick = (rr_last_q == 2'd1) ? 2'd2 : 2'd1;
        end else if (req_v[1]) begin
            rr_pick = 2'd1;
        end else begin
            rr_pick = 2'd2;
        end

        if (starve1 && starve2) begin
            win = (rr_last_q == 2'd1) ? 2'd2 : 2'd1;
        end else if (starve1) begin
            win = 2'd1;
        end else if (starve2) begin
            win = 2'd2;
        end else if (cont) begin
            win = last_q;
        end else if (req_v[0]) begin
            win = 2'd0;
        end else begin
            win = rr_pick;
        end
    end

    // Next state, bookkeeping and SSRAM/ack outputs
    logic          sram_we_c, sram_re_c;
    logic [AW-1:0] sram_adr_c;
    logic [31:0]   sram_dout_c;
    logic [3:0]    ack_c;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        burst_d     = burst_q;
        rr_last_d   = rr_last_q;
        wait1_d     = wait1_q;
        wait2_d     = wait2_q;
        sram_we_c   = 1'b0;
        sram_re_c   = 1'b0;
        sram_adr_c  = '0;
        sram_dout_c = '0;
        ack_c       = 4'b0000;

        case (state_q)
            ST_ISSUE: begin
                if (win_vld) begin
                    sram_adr_c  = adr_v[win];
                    sram_dout_c = din_v[win];
                    sram_we_c   = we_v[win];
                    sram_re_c   = !we_v[win];
                    state_d     = ST_ACK;
                    last_d      = win;
                    if (win == last_q) begin
                        burst_d = (burst_q == '1) ? burst_q : CW'(burst_q + 1'b1);
                    end else begin
                        burst_d = CW'(1);
                    end
                    if (win != 2'd0) begin
                        rr_last_d = win;
                    end
                    // Losing while requesting ages a requester toward forced service
                    if (win == 2'd1) begin
                        wait1_d = '0;
                    end else if (req_v[1] && (wait1_q < CW'(STARVE_LIM))) begin
                        wait1_d = CW'(wait1_q + 1'b1);
                    end
                    if (win == 2'd2) begin
                        wait2_d = '0;
                    end else if (req_v[2] && (wait2_q < CW'(STARVE_LIM))) begin
                        wait2_d = CW'(wait2_q + 1'b1);
                    end
                end
            end
            ST_ACK: begin
                ack_c[last_q] = 1'b1;
                state_d       = ST_ISSUE;
            end
            default: state_d = ST_ISSUE;
        endcase
    end

    always_ff @(posedge phy_clk) begin
        if (rst) begin
            state_q   <= ST_ISSUE;
            last_q    <= NONE;
            burst_q   <= '0;
            rr_last_q <= 2'd2;
            wait1_q   <= '0;
            wait2_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            burst_q   <= burst_d;
            rr_last_q <= rr_last_d;
            wait1_q   <= wait1_d;
            wait2_q   <= wait2_d;
        end
    end

    // Reset masks strobes and acks in the same cycle so an interrupted ACK never completes
    assign bus.sram_adr  = sram_adr_c;
    assign bus.sram_dout = sram_dout_c;
    assign bus.sram_we   = sram_we_c && !rst;
    assign bus.sram_re   = sram_re_c && !rst;
    assign bus.r0_ack    = ack_c[0] && !rst;
    assign bus.r1_ack    = ack_c[1] && !rst;
    assign bus.r2_ack    = ack_c[2] && !rst;
    assign bus.r0_dout   = bus.sram_din;
    assign bus.r1_dout   = bus.sram_din;
    assign bus.r2_dout   = bus.sram_din;
    assign bus.owner     = (state_q == ST_ACK && !rst) ? last_q : NONE;

endmodule

// File: tb/tb_usbf_mem_sched.sv
// Directed bench for usbf_mem_sched with a behavioural SSRAM (read data one
// cycle after address).
module tb_usbf_mem_sched;
    logic clk;
    logic rst;
    int   vec;
    int   errs;
    int   got[$];
    int   maxw;

    logic [31:0] mem [0:32767];

    usbf_mem_sched_if #(.SSRAM_HADR(14)) bus ();

    usbf_mem_sched #(
        .SSRAM_HADR(14),
        .MAX_BURST (4),
        .STARVE_LIM(8)
    ) dut (
        .phy_clk(clk),
        .rst    (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.sram_we) mem[bus.sram_adr] <= bus.sram_dout;
        if (bus.sram_re) bus.sram_din <= mem[bus.sram_adr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        bus.r0_req = 1'b0; bus.r1_req = 1'b0; bus.r2_req = 1'b0;
        bus.r0_we  = 1'b0; bus.r1_we  = 1'b0; bus.r2_we  = 1'b0;
        bus.r0_adr = '0;   bus.r1_adr = '0;   bus.r2_adr = '0;
        bus.r0_din = '0;   bus.r1_din = '0;   bus.r2_din = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_reqs();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Record which requester is acked in each cycle until n acks are seen
    task automatic collect(input int n, input string tag);
        int cyc;
        int ovl;
        int nack;
        cyc  = 0;
        ovl  = 0;
        maxw = 0;
        got.delete();
        while (got.size() < n && cyc < 300) begin
            @(negedge clk);
            nack = int'(bus.r0_ack) + int'(bus.r1_ack) + int'(bus.r2_ack);
            if (nack > 1) ovl++;
            if (bus.r0_ack) got.push_back(0);
            if (bus.r1_ack) got.push_back(1);
            if (bus.r2_ack) got.push_back(2);
            if (int'(dut.wait1_q) > maxw) maxw = int'(dut.wait1_q);
            if (int'(dut.wait2_q) > maxw) maxw = int'(dut.wait2_q);
            cyc++;
        end
        vec++;
        if (got.size() < n) begin
            errs++;
            $display("FAIL %s_timeout: got %0d acks, expected %0d", tag, got.size(), n);
        end
        vec++;
        if (ovl !== 0) begin
            errs++;
            $display("FAIL %s_overlap: got %0d overlapping cycles, expected 0", tag, ovl);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_reqs();
        bus.r1_req = 1'b1;
        tick();
        @(negedge clk);
        vec++;
        if (bus.sram_re !== 1'b0) begin
            errs++;
            $display("FAIL rst_sram_re: got %b expected 0", bus.sram_re);
        end
        do_reset();
        @(negedge clk);
        vec++;
        if (bus.owner !== 2'd3) begin
            errs++;
            $display("FAIL rst_owner: got %0d expected 3", bus.owner);
        end
        vec++;
        if ({bus.r0_ack, bus.r1_ack, bus.r2_ack} !== 3'b000) begin
            errs++;
            $display("FAIL rst_acks: got %b expected 000", {bus.r0_ack, bus.r1_ack, bus.r2_ack});
        end
        vec++;
        if ({bus.sram_we, bus.sram_re, bus.sram_adr, bus.sram_dout} !== '0) begin
            errs++;
            $display("FAIL rst_idle_bus: got we=%b re=%b adr=%h dout=%h expected all 0",
                     bus.sram_we, bus.sram_re, bus.sram_adr, bus.sram_dout);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        mem[15'h0010] = 32'hDEADBEEF;
        bus.r1_req = 1'b1;
        bus.r1_adr = 15'h0010;
        @(negedge clk);
        vec++;
        if (bus.sram_adr !== 15'h0010 || bus.sram_re !== 1'b1 || bus.sram_we !== 1'b0) begin
            errs++;
            $display("FAIL rd_issue: got adr=%h re=%b we=%b expected 0010/1/0",
                     bus.sram_adr, bus.sram_re, bus.sram_we);
        end
        @(posedge clk);
        @(negedge clk);
        vec++;
        if (bus.r1_ack !== 1'b1 || bus.r0_ack !== 1'b0 || bus.r2_ack !== 1'b0) begin
            errs++;
            $display("FAIL rd_ack: got r0/r1/r2=%b%b%b expected 010", bus.r0_ack, bus.r1_ack, bus.r2_ack);
        end
        vec++;
        if (bus.r1_dout !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL rd_data: got %h expected deadbeef", bus.r1_dout);
        end
        vec++;
        if (bus.owner !== 2'd1 || bus.sram_re !== 1'b0) begin
            errs++;
            $display("FAIL rd_owner: got owner=%0d re=%b expected 1/0", bus.owner, bus.sram_re);
        end
        tick();
        bus.r1_req = 1'b0;
        @(negedge clk);
        vec++;
        if (bus.owner !== 2'd3 || bus.sram_re !== 1'b0) begin
            errs++;
            $display("FAIL rd_after: got owner=%0d re=%b expected 3/0", bus.owner, bus.sram_re);
        end
    endtask

    task automatic test_write();
        do_reset();
        bus.r0_req = 1'b1;
        bus.r0_we  = 1'b1;
        bus.r0_adr = 15'h7FFF;
        bus.r0_din = 32'h12345678;
        @(negedge clk);
        vec++;
        if (bus.sram_we !== 1'b1 || bus.sram_re !== 1'b0 || bus.sram_adr !== 15'h7FFF ||
            bus.sram_dout !== 32'h12345678) begin
            errs++;
            $display("FAIL wr_issue: got we=%b re=%b adr=%h dout=%h expected 1/0/7fff/12345678",
                     bus.sram_we, bus.sram_re, bus.sram_adr, bus.sram_dout);
        end
        @(posedge clk);
        @(negedge clk);
        vec++;
        if (bus.r0_ack !== 1'b1 || bus.sram_we !== 1'b0 || bus.owner !== 2'd0) begin
            errs++;
            $display("FAIL wr_ack: got ack=%b we=%b owner=%0d expected 1/0/0",
                     bus.r0_ack, bus.sram_we, bus.owner);
        end
        tick();
        idle_reqs();
        @(negedge clk);
        vec++;
        if (bus.sram_we !== 1'b0) begin
            errs++;
            $display("FAIL wr_once: got we=%b expected 0", bus.sram_we);
        end
        // Read back through r1
        tick();
        bus.r1_req = 1'b1;
        bus.r1_adr = 15'h7FFF;
        collect(1, "wr_rb");
        vec++;
        if (bus.r1_dout !== 32'h12345678) begin
            errs++;
            $display("FAIL wr_readback: got %h expected 12345678", bus.r1_dout);
        end
    endtask

    task automatic test_priority();
        int exp_seq[18];
        exp_seq = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 2, 2, 0, 0, 0, 0, 1};
        do_reset();
        bus.r0_req = 1'b1;
        bus.r1_req = 1'b1;
        bus.r2_req = 1'b1;
        collect(18, "pri");
        for (int i = 0; i < 18; i++) begin
            if (i < got.size()) begin
                vec++;
                if (got[i] !== exp_seq[i]) begin
                    errs++;
                    $display("FAIL pri_slot%0d: got r%0d expected r%0d", i + 1, got[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_seq[12];
        exp_seq = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};
        do_reset();
        bus.r1_req = 1'b1;
        bus.r2_req = 1'b1;
        collect(12, "rr");
        for (int i = 0; i < 12; i++) begin
            if (i < got.size()) begin
                vec++;
                if (got[i] !== exp_seq[i]) begin
                    errs++;
                    $display("FAIL rr_slot%0d: got r%0d expected r%0d", i + 1, got[i], exp_seq[i]);
                end
            end
        end
        vec++;
        if (maxw >= 8) begin
            errs++;
            $display("FAIL rr_wait_max: got %0d expected below 8", maxw);
        end
    endtask

    task automatic test_starvation();
        do_reset();
        bus.r0_req = 1'b1;
        bus.r2_req = 1'b1;
        collect(9, "stv");
        if (got.size() == 9) begin
            vec++;
            if (got[8] !== 2 || got[7] !== 0) begin
                errs++;
                $display("FAIL stv_slot9: got r%0d after r%0d expected r2 after r0", got[8], got[7]);
            end
        end
        vec++;
        if (dut.wait2_q !== 4'd0) begin
            errs++;
            $display("FAIL stv_wait_clear: got %0d expected 0", dut.wait2_q);
        end
    endtask

    task automatic test_reset_mid_ack();
        do_reset();
        bus.r2_req = 1'b1;
        bus.r2_adr = 15'h0005;
        @(negedge clk);
        vec++;
        if (bus.sram_re !== 1'b1 || bus.sram_adr !== 15'h0005) begin
            errs++;
            $display("FAIL rma_issue: got re=%b adr=%h expected 1/0005", bus.sram_re, bus.sram_adr);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        vec++;
        if (bus.r2_ack !== 1'b0 || bus.owner !== 2'd3) begin
            errs++;
            $display("FAIL rma_ack_kill: got ack=%b owner=%0d expected 0/3", bus.r2_ack, bus.owner);
        end
        tick();
        bus.r1_req = 1'b1;
        @(negedge clk);
        vec++;
        if (bus.sram_re !== 1'b0 || bus.sram_we !== 1'b0) begin
            errs++;
            $display("FAIL rma_strobe_in_rst: got re=%b we=%b expected 0/0", bus.sram_re, bus.sram_we);
        end
        tick();
        rst = 1'b0;
        collect(1, "rma");
        if (got.size() >= 1) begin
            vec++;
            if (got[0] !== 1) begin
                errs++;
                $display("FAIL rma_first_grant: got r%0d expected r1", got[0]);
            end
        end
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        rst  = 1'b1;
        idle_reqs();
        test_reset();
        test_single_read();
        test_write();
        test_priority();
        test_round_robin();
        test_starvation();
        test_reset_mid_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
